cla_sub_pipe: RTL
=================

Name: cla_sub_pipe

Overview:
- Two-stage pipelined subtractor built from 4-bit carry-lookahead groups. Computes diff = a - b - bin as a + ~b + ~bin.
- Provides the inverse arithmetic path to the team's CLA adders.
- Splits the operand at WIDTH/2: the low half resolves in stage 1, the high half in stage 2.
- Uses valid/ready handshakes on both sides so it can sit between streaming datapath blocks.

Parameters:
- WIDTH, 32, operand width. Must be a multiple of 8 so each half is whole 4-bit lookahead groups.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result fields are valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out: 1 when unsigned a < b + bin
- ovf  output  1  signed (two's complement) overflow
- zero  output  1  diff == 0

Behaviour:
- Reset: when rst=1 at a clk edge, s1_valid, s2_valid, out_valid, diff, bout, ovf and zero all clear to 0. Any in-flight operation is dropped with no output. in_ready is 1 in the cycle after reset.
- Transfers: an input transfer occurs when in_valid && in_ready at an edge. An output transfer occurs when out_valid && out_ready at an edge.
- Stage 1, on input transfer:
  - Register lo_diff = low WIDTH/2 bits of a + ~b + ~bin, computed with 4-bit group P/G and a lookahead carry chain.
  - Register mid_carry = carry out of the low half.
  - Register the high halves of a and ~b.
  - Set s1_valid.
- Stage 2, on s1 to s2 advance:
  - Compute hi_diff = a_hi + ~b_hi + mid_carry, using the same lookahead structure.
  - Register diff = {hi_diff, lo_diff}.
  - bout = ~carry_out.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - zero = (diff == 0).
  - Set s2_valid; out_valid = s2_valid.
- Latency: exactly 2 cycles from input transfer to out_valid with no stalls. Throughput is 1 result per cycle.
- Ready logic (combinational, no registered ready):
  - s2_can_load = !s2_valid || out_ready
  - s1_can_load = !s1_valid || s2_can_load
  - in_ready = s1_can_load
- Simultaneous events:
  - Output transfer and s1 to s2 advance in the same cycle: stage 2 takes the new result, with no bubble.
  - s1_valid=1 but no advance while a new input arrives: impossible, because in_ready=0 then.
  - Output transfer with no advance: s2_valid clears.
- Stalls: while out_ready=0, diff/bout/ovf/zero hold stable and out_valid stays 1. No result is ever dropped or duplicated. With the pipeline full and out_ready=0, in_ready=0.
- Stage 1 with no advance and no new input holds its contents.
- Wrap-around: diff is modulo 2^WIDTH. bout is the only unsigned-underflow indication.
- Inputs sampled while in_ready=0 are ignored.

Test Plan:
- Basic: WIDTH=32, out_ready=1, send a=5, b=3, bin=0. Required: after 2 cycles diff=0x00000002, bout=0, ovf=0, zero=0, out_valid high for 1 cycle.
- Underflow: send a=0, b=1, bin=0. Required: diff=0xFFFFFFFF, bout=1, ovf=0. Then send a=7, b=7, bin=0. Required: diff=0, zero=1, bout=0.
- Half-boundary borrow and borrow-in:
  - a=0x00010000, b=0x00000001, bin=0: diff=0x0000FFFF, bout=0.
  - a=0x00010000, b=0, bin=1: diff=0x0000FFFF.
- Signed overflow:
  - a=0x80000000, b=1: diff=0x7FFFFFFF, ovf=1, bout=0.
  - a=0x7FFFFFFF, b=0xFFFFFFFF: diff=0x80000000, ovf=1, bout=1.
- Backpressure: stream 4 operations (a=10,20,30,40; b=1) with out_ready=0 for cycles 2-5.
  - in_ready must fall after 2 operations are accepted.
  - The held diff must stay 9.
  - After release the outputs must be exactly 9, 19, 29, 39, in order, with no gaps once flowing.
- Reset mid-operation: accept a=100, b=1, then assert rst for 1 cycle on the next edge. Required: out_valid=0 and diff=0 after reset, no 99 ever emitted, and a new a=3, b=1 yields diff=2 after 2 cycles.

Source files
------------

// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined subtractor, diff = a - b - bin,
// computed as a + ~b + ~bin with 4-bit carry-lookahead groups.
// The low half of the operands resolves in stage 1 and the high half
// in stage 2. Both sides use valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands a, b, bin are valid
//   in_ready   block accepts operands this cycle (combinational)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow-in
//   out_valid  result fields are valid
//   out_ready  consumer accepts the result
//   diff       a - b - bin modulo 2^WIDTH
//   bout       borrow-out (unsigned a < b + bin)
//   ovf        two's-complement overflow
//   zero       diff == 0
//
// WIDTH must be a multiple of 8 so each half is whole 4-bit groups.
module cla_sub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / 4;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        logic             zero;
    } res_t;

    // Half-width adder: per-group P/G, in-group lookahead carries and a
    // group-level lookahead chain. Returns {carry_out, sum}.
    function automatic logic [HALF:0] cla_add(input logic [HALF-1:0] x,
                                              input logic [HALF-1:0] y,
                                              input logic            cin);
        logic [HALF-1:0] p, gen, sum;
        logic [NGRP:0]   gc;
        logic [3:0]      gp, gg, c;
        p     = x ^ y;
        gen   = x & y;
        sum   = '0;
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            gp   = p[4*k +: 4];
            gg   = gen[4*k +: 4];
            c[0] = gc[k];
            c[1] = gg[0] | (gp[0] & gc[k]);
            c[2] = gg[1] | (gp[1] & gg[0]) | (&gp[1:0] & gc[k]);
            c[3] = gg[2] | (gp[2] & gg[1]) | (&gp[2:1] & gg[0])
                 | (&gp[2:0] & gc[k]);
            // group generate | group propagate & carry-in
            gc[k+1] = gg[3] | (gp[3] & gg[2]) | (&gp[3:2] & gg[1])
                    | (&gp[3:1] & gg[0]) | (&gp & gc[k]);
            sum[4*k +: 4] = gp ^ c;
        end
        return {gc[NGRP], sum};
    endfunction

    // Stage 1 state
    logic            s1_valid_q, s1_valid_d;
    logic [HALF-1:0] lo_diff_q, lo_diff_d;
    logic            mid_carry_q, mid_carry_d;
    logic [HALF-1:0] a_hi_q, a_hi_d;
    logic [HALF-1:0] nb_hi_q, nb_hi_d;   // high half of ~b

    // Stage 2 state
    logic s2_valid_q, s2_valid_d;
    res_t res_q, res_d;

    logic [HALF:0] lo_sum, hi_sum;
    logic          s2_can_load, s1_can_load, in_xfer, s1_adv;

    assign s2_can_load = !s2_valid_q || out_ready;
    assign s1_can_load = !s1_valid_q || s2_can_load;
    assign in_ready    = s1_can_load;
    assign in_xfer     = in_valid && s1_can_load;
    assign s1_adv      = s1_valid_q && s2_can_load;

    assign lo_sum = cla_add(a[HALF-1:0], ~b[HALF-1:0], ~bin);
    assign hi_sum = cla_add(a_hi_q, nb_hi_q, mid_carry_q);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        lo_diff_d   = lo_diff_q;
        mid_carry_d = mid_carry_q;
        a_hi_d      = a_hi_q;
        nb_hi_d     = nb_hi_q;
        s2_valid_d  = s2_valid_q;
        res_d       = res_q;

        if (in_xfer) begin
            s1_valid_d  = 1'b1;
            lo_diff_d   = lo_sum[HALF-1:0];
            mid_carry_d = lo_sum[HALF];
            a_hi_d      = a[WIDTH-1:HALF];
            nb_hi_d     = ~b[WIDTH-1:HALF];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            res_d.diff = {hi_sum[HALF-1:0], lo_diff_q};
            res_d.bout = ~hi_sum[HALF];
            // a and ~b share a sign bit exactly when a and b differ in sign
            res_d.ovf  = (a_hi_q[HALF-1] == nb_hi_q[HALF-1]) &&
                         (hi_sum[HALF-1] != a_hi_q[HALF-1]);
            res_d.zero = ~|{hi_sum[HALF-1:0], lo_diff_q};
        end else if (s2_can_load) begin
            // consumed (or already empty) with nothing arriving
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            lo_diff_q   <= '0;
            mid_carry_q <= 1'b0;
            a_hi_q      <= '0;
            nb_hi_q     <= '0;
            s2_valid_q  <= 1'b0;
            res_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_diff_q   <= lo_diff_d;
            mid_carry_q <= mid_carry_d;
            a_hi_q      <= a_hi_d;
            nb_hi_q     <= nb_hi_d;
            s2_valid_q  <= s2_valid_d;
            res_q       <= res_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = res_q.diff;
    assign bout      = res_q.bout;
    assign ovf       = res_q.ovf;
    assign zero      = res_q.zero;
endmodule
